// File: rtl/load_store_unit.sv
// load_store_unit: executes one CPU byte/half/word load or store at a time
// over memory port B. It aligns store data, extracts and extends load data,
// and faults on illegal or misaligned accesses and on memory timeouts.
module load_store_unit #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // CPU side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        mem_wait,
  // memory port B request
  output logic        enb,
  output logic [3:0]  web,
  output logic [31:0] addrb,
  output logic [31:0] dinb,
  // memory port B response
  input  logic [31:0] doutb,
  input  logic        readBValid,
  input  logic [31:0] bReadAddr,
  input  logic        acceptReadB,
  input  logic        acceptWriteB
);

  // The counter only ever has to hold 0 .. WAIT_LIMIT-1.
  localparam int CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DATA,
    S_RESP
  } state_t;

  state_t           r_state;
  logic             r_store;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [CNT_W-1:0] r_cnt;

  logic             w_illegal;
  logic [3:0]       w_web;
  logic [31:0]      w_dinb;
  logic [31:0]      w_lane;
  logic [31:0]      w_load_data;
  logic             w_limit;
  logic             w_hit;

  assign req_ready = (r_state == S_IDLE);
  assign mem_wait  = (r_state == S_REQ) || (r_state == S_WAIT_DATA);

  // This cycle is the last one allowed in REQ/WAIT_DATA before timing out.
  assign w_limit = (r_cnt == CNT_W'(WAIT_LIMIT - 1));

  // Read data only counts when it is for the word we asked for.
  assign w_hit = readBValid && (bReadAddr == addrb);

  // Classify the incoming request: unknown size, unsigned store, or misaligned.
  always_comb begin
    w_illegal = 1'b0;
    case (funct3)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = addr[0];
      3'b010:  w_illegal = (addr[1:0] != 2'b00);
      3'b100:  w_illegal = req_store;
      3'b101:  w_illegal = req_store | addr[0];
      default: w_illegal = 1'b1;
    endcase
  end

  // Byte enables and lane-replicated write data for the incoming store.
  always_comb begin
    w_web  = 4'b1111;
    w_dinb = wdata;
    case (funct3[1:0])
      2'b00: begin
        w_web  = 4'b0001 << addr[1:0];
        w_dinb = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_web  = 4'b0011 << addr[1:0];
        w_dinb = {2{wdata[15:0]}};
      end
      default: begin
        w_web  = 4'b1111;
        w_dinb = wdata;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0 and extend it by access size.
  always_comb begin
    w_lane      = doutb >> {r_addr_lo, 3'b000};
    w_load_data = w_lane;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_load_data = {24'd0, w_lane[7:0]};
      3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_load_data = {16'd0, w_lane[15:0]};
      default: w_load_data = w_lane;
    endcase
  end

  // Access sequencer: owns state, captured request, counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_store    <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr_lo  <= 2'b00;
      r_cnt      <= '0;
      enb        <= 1'b0;
      web        <= 4'b0000;
      addrb      <= 32'd0;
      dinb       <= 32'd0;
      resp_valid <= 1'b0;
      rdata      <= 32'd0;
      fault      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_store   <= req_store;
            r_funct3  <= funct3;
            r_addr_lo <= addr[1:0];
            if (w_illegal) begin
              // Rejected without touching memory.
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              fault      <= 1'b1;
              rdata      <= 32'd0;
            end else begin
              r_state <= S_REQ;
              r_cnt   <= '0;
              enb     <= 1'b1;
              web     <= req_store ? w_web : 4'b0000;
              addrb   <= {addr[31:2], 2'b00};
              dinb    <= req_store ? w_dinb : 32'd0;
            end
          end
        end

        S_REQ: begin
          // A store accepted on the last allowed cycle still completes, but a
          // load accepted then has no budget left for its data and times out.
          if (r_store && acceptWriteB) begin
            r_state    <= S_RESP;
            enb        <= 1'b0;
            web        <= 4'b0000;
            resp_valid <= 1'b1;
            fault      <= 1'b0;
            rdata      <= 32'd0;
          end else if (w_limit) begin
            r_state    <= S_RESP;
            enb        <= 1'b0;
            web        <= 4'b0000;
            resp_valid <= 1'b1;
            fault      <= 1'b1;
            rdata      <= 32'd0;
          end else if (!r_store && acceptReadB) begin
            r_state <= S_WAIT_DATA;
            enb     <= 1'b0;
            web     <= 4'b0000;
            r_cnt   <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_WAIT_DATA: begin
          if (w_hit) begin
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
            fault      <= 1'b0;
            rdata      <= w_load_data;
          end else if (w_limit) begin
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
            fault      <= 1'b1;
            rdata      <= 32'd0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          enb     <= 1'b0;
          web     <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255: maximum cycles in REQ or WAIT_DATA before the access is aborted with fault.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  CPU access request.
REQ-005 SHALL have port req_ready  output  1  high only in IDLE; a request is taken when req_valid&req_ready.
REQ-006 SHALL have port req_store  input  1  1=store, 0=load.
REQ-007 SHALL have port funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, LSB-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  32  extended load result, valid with resp_valid.
REQ-012 SHALL have port fault  output  1  misaligned, illegal funct3 or timeout, valid with resp_valid.
REQ-013 SHALL have port mem_wait  output  1  high in REQ and WAIT_DATA (stall source for the mode FSM).
REQ-014 SHALL have ports enb (output 1), web (output 4), addrb (output 32), dinb (output 32): memory port B request.
REQ-015 SHALL have ports doutb (input 32), readBValid (input 1), bReadAddr (input 32), acceptReadB (input 1), acceptWriteB (input 1): memory port B response.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT_DATA, RESP.
REQ-017 SHALL capture req_store, funct3, addr and wdata into internal registers on the accepting edge; inputs are ignored at all other times.
REQ-018 SHALL, on accept, go IDLE->RESP with fault=1 and no memory transaction when the access is illegal: funct3 not in {000,001,010,100,101}; store with funct3 100/101; H/HU with addr[0]=1; W with addr[1:0]!=0.
REQ-019 SHALL otherwise go IDLE->REQ.
REQ-020 SHALL, in REQ, drive enb=1 and addrb={addr[31:2],2'b00}; loads drive web=0; stores drive web=byte enables and dinb=replicated data.
REQ-021 SHALL generate store enables as: B 4'b0001<<addr[1:0], dinb={4{wdata[7:0]}}; H 4'b0011<<addr[1:0], dinb={2{wdata[15:0]}}; W 4'b1111, dinb=wdata.
REQ-022 SHALL hold enb, web, addrb and dinb stable in REQ until acceptance: acceptWriteB for stores, acceptReadB for loads.
REQ-023 SHALL go REQ->RESP on a store accept, and REQ->WAIT_DATA on a load accept.
REQ-024 SHALL drive enb=0 and web=0 in every state except REQ.
REQ-025 SHALL, in WAIT_DATA, complete only on a cycle with readBValid=1 and bReadAddr==addrb; it SHALL register the extracted data and go to RESP.
REQ-026 SHALL ignore readBValid when the address mismatches.
REQ-027 SHALL extract load data from lane = doutb >> (8*addr[1:0]): B sign-extends bits 7:0; BU zero-extends bits 7:0; H sign-extends bits 15:0; HU zero-extends bits 15:0; W takes all 32 bits.
REQ-028 SHALL keep a cycle counter cleared on entering REQ; if it reaches WAIT_LIMIT in REQ or WAIT_DATA, go to RESP with fault=1 and rdata=0.
REQ-029 SHALL hold RESP for exactly one cycle with resp_valid=1, then return to IDLE; back-to-back requests therefore have a minimum spacing of 1 idle cycle.
REQ-030 SHALL drive rdata=0 for stores and for faults.
REQ-031 SHALL set resp_valid=0 outside RESP; rdata and fault hold their last value.
REQ-032 SHALL give load latency of accept + 1 (REQ) + N accept wait + M data wait + 1 (RESP).

Reset
REQ-033 SHALL, while rst=1 (asynchronously), force state=IDLE, counter=0, enb=0, web=0, addrb=0, dinb=0, resp_valid=0, rdata=0, fault=0.
REQ-034 SHALL make mem_wait=0 and req_ready=1 after release.
REQ-035 SHALL, on reset mid-transaction, drop enb immediately, discard the access without a response, and ignore any subsequent readBValid.

Verification
REQ-036 SB addr=0x103, wdata=0xAB, acceptWriteB after 2 cycles -> web=1000, addrb=0x100, dinb=0xABABABAB held 3 cycles, then one resp_valid with fault=0.
REQ-037 LB addr=0x201, doutb=0x0000F000 with readBValid and bReadAddr=0x200 -> rdata=0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-038 LW addr=0x102 -> no enb ever; resp_valid the next cycle with fault=1; SH addr=0x1 -> same.
REQ-039 Load accepted, readBValid with bReadAddr=0x204 (wrong) then 0x200 (correct) -> the first is ignored, rdata comes from the second.
REQ-040 WAIT_LIMIT=4, acceptReadB never asserted -> fault=1 on resp_valid exactly 4 cycles after entering REQ.
REQ-041 rst pulse while in WAIT_DATA -> enb=0, resp_valid=0, req_ready=1; a late readBValid produces no response.
